// File: rtl/mult_sequencer.sv
`default_nettype none
//==============================================================================
// mult_sequencer : operand FIFO feeding an IDLE/ISSUE/WAIT/HOLD job sequencer
//                  for an external multiplier. Define SEQ_TIMEOUT_EN for a WAIT timeout.
// Revision       : 1.0
//==============================================================================
module mult_sequencer #(
    parameter int OP_W    = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              start,
    output logic [OP_W-1:0]   op_a,
    output logic [OP_W-1:0]   op_b,
    input  logic              done,
    input  logic [2*OP_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*OP_W-1:0] out_data,
    output logic              busy,
    output logic              timeout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || OP_W < 1) begin : g_param_check
        $error("mult_sequencer: DEPTH must be a power of 2 >= 2, TIMEOUT and OP_W >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2*OP_W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_capture;

    assign w_full   = (r_count == C_FULL);
    assign w_empty  = (r_count == '0);
    assign in_ready = ~w_full;
    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign w_push   = in_valid & ~w_full;

    assign start     = (r_state == S_ISSUE);
    assign out_valid = (r_state == S_HOLD);
    assign busy      = (r_state != S_IDLE);

`ifdef SEQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] C_WAIT_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_wait_cnt;
    logic            r_timeout;
    logic            w_expire;

    // Counter reads 0 in the first WAIT cycle, so TIMEOUT-1 marks the last counted cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (r_state == S_ISSUE)
                r_wait_cnt <= '0;
            else if (r_state == S_WAIT)
                r_wait_cnt <= r_wait_cnt + TO_W'(1);
            if (w_expire)
                r_timeout <= 1'b1;
            else if (w_capture)
                r_timeout <= 1'b0;
        end
    end

    assign timeout = r_timeout & out_valid;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        w_expire    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_ISSUE;
                    w_pop       = 1'b1;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (r_wait_cnt == C_WAIT_LAST) begin
                    w_expire    = 1'b1;
                    w_state_nxt = S_HOLD;
                end
`endif
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (!w_empty) begin
                        w_state_nxt = S_ISSUE;
                        w_pop       = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {in_a, in_b};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            op_a     <= '0;
            op_b     <= '0;
            out_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            // Operands are latched on the edge that enters ISSUE, so they are stable while start is high.
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + PTR_W'(1);
                {op_a, op_b} <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_capture)
                out_data <= product;
`ifdef SEQ_TIMEOUT_EN
            else if (w_expire)
                out_data <= '1;
`endif
        end
    end

endmodule
`default_nettype wire
